// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mstatus/mtvec/mepc/mcause plus mcycle/minstret counters.
// Combinational source reads, registered destination writes, ecall/mret trap-state updates.
module csr_regfile #(
    parameter int              CPU_WIDTH = 64,
    parameter int              CSR_ADDRW = 12,
    parameter logic [63:0]     MTVEC_RST = 64'h0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CSR_ADDRW-1:0] i_csrsid,
    input  logic                 i_csrsren,
    output logic [CPU_WIDTH-1:0] o_csrsdata,
    output logic                 o_csrillegal,
    input  logic [CSR_ADDRW-1:0] i_csrdid,
    input  logic                 i_csrdwen,
    input  logic [CPU_WIDTH-1:0] i_csrddata,
    input  logic                 i_commit,
    input  logic                 i_ecall,
    input  logic                 i_mret,
    input  logic [CPU_WIDTH-1:0] i_pc,
    output logic [CPU_WIDTH-1:0] o_trap_pc,
    output logic [CPU_WIDTH-1:0] o_mret_pc
);

    localparam logic [CSR_ADDRW-1:0] ADDR_MSTATUS  = CSR_ADDRW'('h300);
    localparam logic [CSR_ADDRW-1:0] ADDR_MTVEC    = CSR_ADDRW'('h305);
    localparam logic [CSR_ADDRW-1:0] ADDR_MEPC     = CSR_ADDRW'('h341);
    localparam logic [CSR_ADDRW-1:0] ADDR_MCAUSE   = CSR_ADDRW'('h342);
    localparam logic [CSR_ADDRW-1:0] ADDR_MCYCLE   = CSR_ADDRW'('hB00);
    localparam logic [CSR_ADDRW-1:0] ADDR_MINSTRET = CSR_ADDRW'('hB02);

    localparam logic [CPU_WIDTH-1:0] MTVEC_RST_W = CPU_WIDTH'(MTVEC_RST);

    logic                 mstatus_mie;
    logic                 mstatus_mpie;
    logic [CPU_WIDTH-3:0] mtvec_base;
    logic [CPU_WIDTH-3:0] mepc_base;
    logic [CPU_WIDTH-1:0] mcause;
    logic [CPU_WIDTH-1:0] mcycle;
    logic [CPU_WIDTH-1:0] minstret;

    logic                 do_ecall;
    logic                 do_mret;
    logic [CPU_WIDTH-1:0] mstatus_val;
    logic [CPU_WIDTH-1:0] mtvec_val;
    logic [CPU_WIDTH-1:0] mepc_val;
    logic [CPU_WIDTH-1:0] rd_data;
    logic                 rd_hit;

    assign do_ecall = i_commit & i_ecall;
    assign do_mret  = i_commit & i_mret & ~i_ecall;

    // MPP is hard-wired to machine mode; only MIE and MPIE are real state.
    always_comb begin
        mstatus_val       = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]    = mstatus_mpie;
        mstatus_val[3]    = mstatus_mie;
    end

    assign mtvec_val = {mtvec_base, 2'b00};
    assign mepc_val  = {mepc_base, 2'b00};

    always_comb begin
        rd_hit  = 1'b1;
        rd_data = '0;
        case (i_csrsid)
            ADDR_MSTATUS:  rd_data = mstatus_val;
            ADDR_MTVEC:    rd_data = mtvec_val;
            ADDR_MEPC:     rd_data = mepc_val;
            ADDR_MCAUSE:   rd_data = mcause;
            ADDR_MCYCLE:   rd_data = mcycle;
            ADDR_MINSTRET: rd_data = minstret;
            default:       rd_hit  = 1'b0;
        endcase
    end

    assign o_csrsdata   = i_csrsren ? rd_data : '0;
    assign o_csrillegal = i_csrsren & ~rd_hit;
    assign o_trap_pc    = mtvec_val;
    assign o_mret_pc    = mepc_val;

    // Trap events override software writes to the registers they touch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec_base   <= MTVEC_RST_W[CPU_WIDTH-1:2];
            mepc_base    <= '0;
            mcause       <= '0;
            mcycle       <= '0;
            minstret     <= '0;
        end else begin
            if (do_ecall) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (do_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (i_csrdwen && i_csrdid == ADDR_MSTATUS) begin
                mstatus_mie  <= i_csrddata[3];
                mstatus_mpie <= i_csrddata[7];
            end

            if (i_csrdwen && i_csrdid == ADDR_MTVEC)
                mtvec_base <= i_csrddata[CPU_WIDTH-1:2];

            if (do_ecall) begin
                mepc_base <= i_pc[CPU_WIDTH-1:2];
                mcause    <= CPU_WIDTH'(11);
            end else begin
                if (i_csrdwen && i_csrdid == ADDR_MEPC)
                    mepc_base <= i_csrddata[CPU_WIDTH-1:2];
                if (i_csrdwen && i_csrdid == ADDR_MCAUSE)
                    mcause <= i_csrddata;
            end

            if (i_csrdwen && i_csrdid == ADDR_MCYCLE)
                mcycle <= i_csrddata;
            else
                mcycle <= mcycle + CPU_WIDTH'(1);

            if (i_csrdwen && i_csrdid == ADDR_MINSTRET)
                minstret <= i_csrddata;
            else if (i_commit)
                minstret <= minstret + CPU_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile: reset, read/write masking,
// ecall/mret sequencing, counter wrap and write priority, unimplemented addresses.
module tb_csr_regfile;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [11:0] i_csrsid;
    logic        i_csrsren;
    logic [63:0] o_csrsdata;
    logic        o_csrillegal;
    logic [11:0] i_csrdid;
    logic        i_csrdwen;
    logic [63:0] i_csrddata;
    logic        i_commit;
    logic        i_ecall;
    logic        i_mret;
    logic [63:0] i_pc;
    logic [63:0] o_trap_pc;
    logic [63:0] o_mret_pc;

    int testCount = 0;
    int failCount = 0;

    csr_regfile #(.CPU_WIDTH(64), .CSR_ADDRW(12), .MTVEC_RST(64'h0)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_csrsid(i_csrsid), .i_csrsren(i_csrsren),
        .o_csrsdata(o_csrsdata), .o_csrillegal(o_csrillegal),
        .i_csrdid(i_csrdid), .i_csrdwen(i_csrdwen), .i_csrddata(i_csrddata),
        .i_commit(i_commit), .i_ecall(i_ecall), .i_mret(i_mret), .i_pc(i_pc),
        .o_trap_pc(o_trap_pc), .o_mret_pc(o_mret_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkCsr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        i_csrsid  = addr;
        i_csrsren = 1'b1;
        #0.5;
        checkOutput(tag, o_csrsdata, exp);
        i_csrsren = 1'b0;
    endtask

    task automatic writeCsr(input logic [11:0] addr, input logic [63:0] data);
        i_csrdid   = addr;
        i_csrddata = data;
        i_csrdwen  = 1'b1;
        applyStimulus();
        i_csrdwen  = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkCsr({tag, "_mstatus"},  12'h300, 64'h1800);
        checkCsr({tag, "_mtvec"},    12'h305, 64'h0);
        checkCsr({tag, "_mepc"},     12'h341, 64'h0);
        checkCsr({tag, "_mcause"},   12'h342, 64'h0);
        checkCsr({tag, "_mcycle"},   12'hB00, 64'h0);
        checkCsr({tag, "_minstret"}, 12'hB02, 64'h0);
        checkOutput({tag, "_trap_pc"}, o_trap_pc, 64'h0);
        checkOutput({tag, "_mret_pc"}, o_mret_pc, 64'h0);
    endtask

    initial begin
        i_rst = 1'b1; i_csrsid = '0; i_csrsren = 1'b0;
        i_csrdid = '0; i_csrdwen = 1'b0; i_csrddata = '0;
        i_commit = 1'b0; i_ecall = 1'b0; i_mret = 1'b0; i_pc = '0;
        applyStimulus();
        applyStimulus();
        i_rst = 1'b0;

        checkResetState("rst");
        i_csrsid = 12'h300;
        #0.5;
        checkOutput("rden_low_data", o_csrsdata, 64'h0);
        checkOutput("rden_low_illegal", {63'b0, o_csrillegal}, 64'h0);
        applyStimulus(); applyStimulus(); applyStimulus();
        checkCsr("mcycle_after3", 12'hB00, 64'd3);

        // mtvec low bits masked; same-cycle read sees old value
        i_csrdid = 12'h305; i_csrddata = 64'h8000_0003; i_csrdwen = 1'b1;
        checkCsr("mtvec_same_cycle", 12'h305, 64'h0);
        applyStimulus();
        i_csrdwen = 1'b0;
        checkCsr("mtvec_masked", 12'h305, 64'h8000_0000);
        checkOutput("trap_pc", o_trap_pc, 64'h8000_0000);

        writeCsr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        checkCsr("mstatus_all_ones", 12'h300, 64'h1888);

        // ecall with a competing mepc write: ecall must win
        i_commit = 1'b1; i_ecall = 1'b1; i_pc = 64'h8000_0104;
        i_csrdid = 12'h341; i_csrddata = 64'h1234; i_csrdwen = 1'b1;
        applyStimulus();
        i_commit = 1'b0; i_ecall = 1'b0; i_csrdwen = 1'b0;
        checkCsr("ecall_mepc", 12'h341, 64'h8000_0104);
        checkCsr("ecall_mcause", 12'h342, 64'd11);
        checkCsr("ecall_mstatus", 12'h300, 64'h1880);
        checkOutput("ecall_mret_pc", o_mret_pc, 64'h8000_0104);

        i_commit = 1'b1; i_mret = 1'b1;
        applyStimulus();
        i_commit = 1'b0; i_mret = 1'b0;
        checkCsr("mret_mstatus", 12'h300, 64'h1888);
        checkOutput("mret_pc", o_mret_pc, 64'h8000_0104);

        i_ecall = 1'b1; i_pc = 64'h40;
        applyStimulus();
        i_ecall = 1'b0;
        checkCsr("ecall_nocommit_mstatus", 12'h300, 64'h1888);
        checkCsr("ecall_nocommit_mepc", 12'h341, 64'h8000_0104);

        writeCsr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        checkCsr("mcycle_preload", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus();
        checkCsr("mcycle_wrap", 12'hB00, 64'h0);
        writeCsr(12'hB00, 64'd5);
        checkCsr("mcycle_write5", 12'hB00, 64'd5);
        applyStimulus();
        checkCsr("mcycle_inc6", 12'hB00, 64'd6);

        writeCsr(12'hB02, 64'd0);
        for (int i = 0; i < 20; i++) begin
            i_commit = (i % 2 == 0);
            applyStimulus();
        end
        i_commit = 1'b0;
        checkCsr("minstret_10", 12'hB02, 64'd10);
        i_commit = 1'b1;
        writeCsr(12'hB02, 64'd100);
        i_commit = 1'b0;
        checkCsr("minstret_write_prio", 12'hB02, 64'd100);

        i_csrsid = 12'h7C0; i_csrsren = 1'b1;
        #0.5;
        checkOutput("unimpl_data", o_csrsdata, 64'h0);
        checkOutput("unimpl_illegal", {63'b0, o_csrillegal}, 64'h1);
        i_csrsren = 1'b0;
        writeCsr(12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkCsr("unimpl_wr_mstatus", 12'h300, 64'h1888);
        checkCsr("unimpl_wr_mtvec", 12'h305, 64'h8000_0000);
        checkCsr("unimpl_wr_mepc", 12'h341, 64'h8000_0104);
        checkCsr("unimpl_wr_mcause", 12'h342, 64'd11);

        // ecall and mret together: ecall wins, pc low bits dropped
        i_commit = 1'b1; i_ecall = 1'b1; i_mret = 1'b1; i_pc = 64'h447;
        applyStimulus();
        i_commit = 1'b0; i_ecall = 1'b0; i_mret = 1'b0;
        checkCsr("both_mstatus", 12'h300, 64'h1880);
        checkCsr("both_mepc", 12'h341, 64'h444);

        i_rst = 1'b1; i_commit = 1'b1; i_ecall = 1'b1; i_pc = 64'h200;
        i_csrdid = 12'h305; i_csrddata = 64'hFF; i_csrdwen = 1'b1;
        applyStimulus();
        i_rst = 1'b0; i_commit = 1'b0; i_ecall = 1'b0; i_csrdwen = 1'b0;
        checkResetState("rst_ecall");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
